// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_t;

    localparam int OVS_DEF   = 16;
    localparam int DIV_W_DEF = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every div+1 clocks while enabled.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == div) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchronizer, oversampling FSM, parity check and a
// single-entry ready/valid output register with overrun detection.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVS   = OVS_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             rx_in,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             rx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun,
    output logic             busy
);

    localparam int TCNT_W = $clog2(OVS);
    localparam logic [TCNT_W-1:0] T_HALF = TCNT_W'(OVS / 2 - 1);
    localparam logic [TCNT_W-1:0] T_LAST = TCNT_W'(OVS - 1);

    rx_state_t        state_q, state_d;
    logic [1:0]       sync_q;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [DIV_W-1:0] div_l_q, div_l_d;
    logic             pen_l_q, pen_l_d;
    logic             podd_l_q, podd_l_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;
    logic             rxs;
    logic             tick;

    assign rxs = sync_q[1];

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk      (clk),
        .areset_n (areset_n),
        .en       (state_q != S_IDLE),
        .div      (div_l_q),
        .tick     (tick)
    );

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        div_l_d  = div_l_q;
        pen_l_d  = pen_l_q;
        podd_l_d = podd_l_q;
        data_d   = data_q;
        valid_d  = valid_q && !rx_ready;
        ferr_d   = 1'b0;
        perr_d   = 1'b0;
        ovr_d    = 1'b0;

        if (tick) begin
            tcnt_d = (tcnt_q == T_LAST) ? '0 : tcnt_q + TCNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d  = S_START;
                    tcnt_d   = '0;
                    div_l_d  = baud_div;
                    pen_l_d  = parity_en;
                    podd_l_d = parity_odd;
                end
            end
            S_START: begin
                // Mid start bit: a line back high here was only a glitch.
                if (tick && tcnt_q == T_HALF) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_DATA;
                        tcnt_d   = '0;
                        bitcnt_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick && tcnt_q == T_LAST) begin
                    shift_d  = {rxs, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = pen_l_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick && tcnt_q == T_LAST) begin
                    par_d   = rxs;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick && tcnt_q == T_LAST) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                        if (pen_l_q && ((^shift_q) ^ par_q ^ podd_l_q)) begin
                            perr_d = 1'b1;
                        end else if (valid_q && !rx_ready) begin
                            ovr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q  <= S_IDLE;
            sync_q   <= 2'b11;
            tcnt_q   <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            div_l_q  <= '0;
            pen_l_q  <= 1'b0;
            podd_l_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[0], rx_in};
            tcnt_q   <= tcnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            div_l_q  <= div_l_d;
            pen_l_q  <= pen_l_d;
            podd_l_q <= podd_l_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: serial frames in, bytes and error pulses out.
module tb_uart_rx_ctrl;

    localparam int DIV_W   = 16;
    localparam int OVS     = 16;
    localparam int BIT_CLK = 2 * OVS;

    logic             clk = 1'b0;
    logic             areset_n;
    logic             rx_in;
    logic [DIV_W-1:0] baud_div;
    logic             parity_en;
    logic             parity_odd;
    logic             rx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             frame_err;
    logic             parity_err;
    logic             overrun;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int n_ferr = 0, n_perr = 0, n_ovr = 0;
    int b_ferr, b_perr, b_ovr;
    logic [7:0] exp_q[$];

    uart_rx_ctrl #(.OVS(OVS), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .rx_in      (rx_in),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (areset_n) begin
            if (frame_err)  n_ferr++;
            if (parity_err) n_perr++;
            if (overrun)    n_ovr++;
            if (rx_valid && rx_ready) begin
                chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pe, input bit pb, input bit sb);
        rx_in = 1'b0;
        cyc(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            cyc(BIT_CLK);
        end
        if (pe) begin
            rx_in = pb;
            cyc(BIT_CLK);
        end
        rx_in = sb;
        cyc(BIT_CLK);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            cyc(1);
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic snap();
        b_ferr = n_ferr;
        b_perr = n_perr;
        b_ovr  = n_ovr;
    endtask

    task automatic chk_err(input string tag, input int df, input int dp, input int dovr);
        chk({tag, "_ferr"}, 32'(n_ferr - b_ferr), 32'(df));
        chk({tag, "_perr"}, 32'(n_perr - b_perr), 32'(dp));
        chk({tag, "_ovr"},  32'(n_ovr - b_ovr),   32'(dovr));
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, {18'd0, rx_data, rx_valid, frame_err, parity_err, overrun, busy, 1'b0}, 32'd0);
    endtask

    initial begin
        logic [7:0] part;
        areset_n   = 1'b0;
        rx_in      = 1'b1;
        baud_div   = DIV_W'(1);
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        rx_ready   = 1'b1;
        cyc(3);
        chk_outs_zero("reset_outs");
        areset_n = 1'b1;
        cyc(BIT_CLK);

        // plain 8N1 frame
        snap();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        wait_idle();
        cyc(4);
        chk_err("a5", 0, 0, 0);
        chk("a5_sb_empty", 32'(exp_q.size()), 32'd0);

        // even parity: bad then good, then odd parity
        parity_en = 1'b1;
        snap();
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        wait_idle();
        cyc(4);
        chk_err("par_bad", 0, 1, 0);
        chk("par_bad_valid", {31'd0, rx_valid}, 32'd0);
        snap();
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        wait_idle();
        cyc(4);
        chk_err("par_ok", 0, 0, 0);
        parity_odd = 1'b1;
        snap();
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        wait_idle();
        cyc(4);
        chk_err("par_odd", 0, 0, 0);
        chk("par_sb_empty", 32'(exp_q.size()), 32'd0);
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        // stop bit low
        snap();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        cyc(BIT_CLK);
        chk("wait_high_busy", {31'd0, busy}, 32'd1);
        chk_err("ferr", 1, 0, 0);
        rx_in = 1'b1;
        cyc(5);
        chk("wait_high_exit", {31'd0, busy}, 32'd0);
        snap();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        wait_idle();
        cyc(4);
        chk_err("after_ferr", 0, 0, 0);
        chk("ferr_sb_empty", 32'(exp_q.size()), 32'd0);

        // short low glitch
        snap();
        rx_in = 1'b0;
        cyc(4);
        rx_in = 1'b1;
        cyc(4);
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        cyc(30);
        chk("glitch_idle", {31'd0, busy}, 32'd0);
        chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
        chk_err("glitch", 0, 0, 0);

        // back-to-back with consumer always ready
        snap();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        wait_idle();
        cyc(4);
        chk_err("b2b", 0, 0, 0);
        chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        // consumer stalled: second byte overruns
        rx_ready = 1'b0;
        snap();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        wait_idle();
        cyc(4);
        chk_err("ovr", 0, 0, 1);
        chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
        chk("ovr_data", {24'd0, rx_data}, 32'h11);
        rx_ready = 1'b1;
        cyc(3);
        chk("ovr_drained", {31'd0, rx_valid}, 32'd0);
        chk("ovr_sb_empty", 32'(exp_q.size()), 32'd0);

        // reset in the middle of data bit 4 with a byte still held
        rx_ready = 1'b0;
        send_frame(8'h99, 1'b0, 1'b0, 1'b1);
        wait_idle();
        cyc(2);
        chk("held_valid", {31'd0, rx_valid}, 32'd1);
        chk("held_data", {24'd0, rx_data}, 32'h99);
        part = 8'h3C;
        rx_in = 1'b0;
        cyc(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx_in = part[i];
            cyc(BIT_CLK);
        end
        rx_in = part[4];
        cyc(BIT_CLK / 2);
        chk("midframe_busy", {31'd0, busy}, 32'd1);
        snap();
        areset_n = 1'b0;
        #1;
        chk_outs_zero("rst_async_outs");
        rx_in = 1'b1;
        cyc(5);
        chk_outs_zero("rst_hold_outs");
        areset_n = 1'b1;
        rx_ready = 1'b1;
        cyc(3 * BIT_CLK);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        chk("post_rst_valid", {31'd0, rx_valid}, 32'd0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        wait_idle();
        cyc(4);
        chk_err("post_rst", 0, 0, 0);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
